fifo_base_unpacker: RTL
=======================

Name: fifo_base_unpacker

Overview:
- Read-side consumer of the 16-bit sequence FIFO. It drains packed reference/read words and serialises each into eight 2-bit nucleotide symbols for the downstream matcher.
- It owns the FIFO rd_en and absorbs the FIFO's one-cycle registered read latency.
- It presents a valid/ready symbol stream and sustains 1 base/cycle while the FIFO stays non-empty.

Parameters:
- DATA_W, 16, packed FIFO word width; must be a multiple of SYM_W.
- SYM_W, 2, bits per nucleotide: A=00, C=01, G=10, T=11.
- BASES_PER_WORD (localparam), DATA_W/SYM_W = 8, symbols per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO buf_empty.
- fifo_data  in  DATA_W  FIFO buf_out; valid the cycle after an accepted rd_en.
- fifo_rd_en  out  1  FIFO pop request.
- base_out  out  SYM_W  current nucleotide.
- base_valid  out  1  base_out is valid.
- base_ready  in  1  downstream accepts; transfer occurs when valid && ready.
- base_last  out  1  base_out is the final symbol of its word.
- base_count  out  32  bases transferred (see Optional Feature).

Behaviour:
- Reset (async): fifo_rd_en=0, base_out=0, base_valid=0, base_last=0, base_count=0. Internally pending=0, pf_valid=0, cnt=0, sr=0. Reset mid-operation discards any in-flight FIFO read and any partially emitted word without replaying it.
- fifo_rd_en is combinational: !fifo_empty && !pending && !pf_valid. This allows at most one outstanding read and prevents a pop on empty.
- pending register: set the cycle after fifo_rd_en=1, cleared on the next cycle.
- While pending=1: pf <= fifo_data and pf_valid <= 1 at the clock edge.
- Shift stage holds sr[DATA_W-1:0] and cnt (0..8).
  - base_out = sr[DATA_W-1 -: SYM_W], so symbols go out MSB-first: bits[15:14] first, bits[1:0] last.
  - base_valid = (cnt != 0).
  - base_last = (cnt == 1).
- On a transfer with cnt > 1: sr <= sr << SYM_W, cnt <= cnt-1.
- Load condition: pf_valid && (cnt==0 || (cnt==1 && base_valid && base_ready)). On load: sr <= pf, cnt <= 8, pf_valid <= 0. This gives gap-free word-to-word streaming.
- A transfer with cnt==1 and no pf_valid sets cnt <= 0, and base_valid deasserts the next cycle.
- Backpressure: while base_valid && !base_ready, base_out, base_last, sr and cnt hold. The prefetch may still fill, but no further FIFO read is issued while pf_valid=1.
- Latency: rd_en in cycle t, fifo_data in t+1, pf_valid in t+2, first base_valid in t+3.
- Simultaneous pf capture and pf load cannot occur because issue requires !pf_valid; the design must not rely on bypassing.
- When fifo_empty is high, no read is issued. The stream drains the remaining cnt+pf bases, then idles with base_valid=0.

Optional Feature:
- Macro UNPACK_BASE_COUNT_EN.
- Defined: base_count increments by 1 on every valid&&ready transfer and saturates at 32'hFFFF_FFFF. It resets to 0.
- Undefined: base_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package dna_pkg holds:
  - DATA_W and SYM_W constants.
  - nucleotide encoding constants BASE_A/C/G/T.
  - BASES_PER_WORD.
- One natural sub-module, base_shift_reg: sr/cnt, load, shift, base_valid/base_last. The top keeps the rd_en/pending/prefetch control.

Test Plan:
- FIFO preloaded with 16'h1B1B, base_ready=1 → base_out sequence 0,1,2,3,0,1,2,3, base_last only on the 8th base, exactly one fifo_rd_en pulse, first base_valid 3 cycles after rd_en.
- Two words 16'hFFFF then 16'h0000, base_ready=1 → 16 consecutive valid cycles (eight 3s then eight 0s) with no bubble; base_count=16 with UNPACK_BASE_COUNT_EN defined.
- base_ready toggled 1,0,0,1 while streaming 16'hE4E4 → base_out holds its value across stall cycles, sequence 3,2,1,0,3,2,1,0 is intact, fifo_rd_en never asserted while pf_valid=1.
- fifo_empty held high → fifo_rd_en stays 0, base_valid stays 0 indefinitely; when empty drops, a read is issued in the same cycle.
- rst pulsed after the 3rd base of 16'h1B1B with a second word prefetched → all outputs return to reset values asynchronously, no stale bases after release; the next emitted word is the next FIFO entry.
- UNPACK_BASE_COUNT_EN undefined, 4 words streamed → base_count reads 0 throughout.

Source files
------------

// File: rtl/dna_pkg.sv
// Shared nucleotide definitions for the sequence datapath: packed word
// geometry and the 2-bit base encoding.
package dna_pkg;

  localparam int DATA_W         = 16;
  localparam int SYM_W          = 2;
  localparam int BASES_PER_WORD = DATA_W / SYM_W;

  // 2-bit nucleotide encoding used on every symbol stream.
  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

endpackage

// File: rtl/base_shift_reg.sv
// Serialising stage of the base unpacker: holds one packed word and emits its
// symbols MSB-first on a valid/ready stream, reloading from the prefetch slot
// on the last symbol so consecutive words stream without a bubble.
module base_shift_reg
  import dna_pkg::*;
#(
  parameter int DATA_W = dna_pkg::DATA_W,
  parameter int SYM_W  = dna_pkg::SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_valid,
  input  logic [DATA_W-1:0] pf_data,
  input  logic              base_ready,
  output logic              load,
  output logic [SYM_W-1:0]  base_out,
  output logic              base_valid,
  output logic              base_last
);

  localparam int BPW   = DATA_W / SYM_W;
  localparam int CNT_W = $clog2(BPW + 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer;

  assign base_out   = sr_q[DATA_W-1 -: SYM_W];
  assign base_valid = (cnt_q != '0);
  assign base_last  = (cnt_q == CNT_W'(1));
  assign xfer       = base_valid && base_ready;

  // Reload when empty, or when the final symbol leaves this very cycle.
  assign load = pf_valid && ((cnt_q == '0) || (base_last && xfer));

  // Next-state for the word register and remaining-symbol count.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = pf_data;
      cnt_d = CNT_W'(BPW);
    end else if (xfer) begin
      if (cnt_q > CNT_W'(1)) begin
        sr_d  = sr_q << SYM_W;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Word and count registers; reset drops any partially emitted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_base_unpacker.sv
// Read-side consumer of the packed sequence FIFO. Pops one word at a time,
// absorbs the FIFO's one-cycle read latency into a single prefetch slot and
// hands words to base_shift_reg for MSB-first symbol streaming.
// Optional feature macro: UNPACK_BASE_COUNT_EN (saturating transfer counter
// on base_count; when undefined base_count is constant zero).
module fifo_base_unpacker
  import dna_pkg::*;
#(
  parameter int DATA_W = dna_pkg::DATA_W,
  parameter int SYM_W  = dna_pkg::SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [SYM_W-1:0]  base_out,
  output logic              base_valid,
  input  logic              base_ready,
  output logic              base_last,
  output logic [31:0]       base_count
);

  logic              pending_q, pending_d;
  logic              pf_valid_q, pf_valid_d;
  logic [DATA_W-1:0] pf_q, pf_d;
  logic              load;

  // One read outstanding at most, and only into an empty prefetch slot.
  assign fifo_rd_en = !rst && !fifo_empty && !pending_q && !pf_valid_q;

  // Prefetch slot: capture the returning FIFO word, release it on load.
  // Capture and load never coincide since a read needs an empty slot.
  always_comb begin
    pending_d  = fifo_rd_en;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    if (pending_q) begin
      pf_d       = fifo_data;
      pf_valid_d = 1'b1;
    end else if (load) begin
      pf_valid_d = 1'b0;
    end else begin
      pf_valid_d = pf_valid_q;
    end
  end

  // Read-tracking and prefetch registers; an in-flight read is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      pf_valid_q <= pf_valid_d;
      pf_q       <= pf_d;
    end
  end

  base_shift_reg #(
    .DATA_W (DATA_W),
    .SYM_W  (SYM_W)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .pf_valid   (pf_valid_q),
    .pf_data    (pf_q),
    .base_ready (base_ready),
    .load       (load),
    .base_out   (base_out),
    .base_valid (base_valid),
    .base_last  (base_last)
  );

`ifdef UNPACK_BASE_COUNT_EN
  logic [31:0] count_q, count_d;

  // Count accepted symbols, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (base_valid && base_ready && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign base_count = count_q;
`else
  assign base_count = 32'd0;
`endif

endmodule
